// File: rtl/tenyr_bus_defs.sv
// -----------------------------------------------------------------------------
// tenyr_bus_defs
// Shared definitions for the operand data bus: arbiter FSM state encodings,
// default address map (operand RAM window and serial device word) and the
// address/data width used by every block on the bus.
// No ports (package).
// -----------------------------------------------------------------------------
package tenyr_bus_defs;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Wait-state counter width; covers the full 0..15 range.
    localparam int WAIT_W = 4;

    localparam logic [ADDR_W-1:0] DEF_MEM_BASE = 32'd0;
    localparam logic [ADDR_W-1:0] DEF_MEM_SIZE = 32'd8;
    localparam logic [ADDR_W-1:0] DEF_SER_BASE = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

endpackage

// File: rtl/tenyr_addr_decode.sv
// -----------------------------------------------------------------------------
// tenyr_addr_decode
// Combinational word-address decoder for the operand bus address map.
// Also intended for reuse by the instruction fetch path.
//
// Ports:
//   addr      in   32  word address to decode
//   sel_mem   out  1   address falls inside the operand RAM window
//   sel_ser   out  1   address is the serial device word
//   unmapped  out  1   address hits no device
// -----------------------------------------------------------------------------
module tenyr_addr_decode
    import tenyr_bus_defs::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE = DEF_MEM_BASE,
    parameter logic [ADDR_W-1:0] MEM_SIZE = DEF_MEM_SIZE,
    parameter logic [ADDR_W-1:0] SER_BASE = DEF_SER_BASE
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              sel_mem,
    output logic              sel_ser,
    output logic              unmapped
);

    // Window bounds are formed in ADDR_W+1 bits so that a RAM window ending
    // at the top of the address space does not wrap to a small limit.
    logic [ADDR_W:0] addr_x;
    logic [ADDR_W:0] mem_lo;
    logic [ADDR_W:0] mem_hi;

    assign addr_x = {1'b0, addr};
    assign mem_lo = {1'b0, MEM_BASE};
    assign mem_hi = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    assign sel_mem  = (addr_x >= mem_lo) && (addr_x < mem_hi);
    // RAM wins if the serial word is placed inside the RAM window.
    assign sel_ser  = !sel_mem && (addr == SER_BASE);
    assign unmapped = !sel_mem && !sel_ser;

endmodule

// File: rtl/tenyr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tenyr_bus_arbiter
// Two-master round-robin arbiter and sequencer for the shared operand bus
// (operand RAM port plus memory-mapped serial device). One transfer at a
// time: grant, decode, hold the bus for WAIT+1 cycles, capture read data,
// then return a one-cycle ack (with err for unmapped addresses).
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   m0_* / m1_*              master request/rw/addr/wdata in;
//                            rdata/ack/err out (rdata, err valid with ack)
//   bus_enable, bus_rw       device enable and direction (1 = write)
//   bus_addr, bus_wdata      address and write data to devices
//   bus_rdata                muxed device read data
//   sel_mem, sel_ser         one-hot device select during an access
// -----------------------------------------------------------------------------
module tenyr_bus_arbiter
    import tenyr_bus_defs::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE = DEF_MEM_BASE,
    parameter logic [ADDR_W-1:0] MEM_SIZE = DEF_MEM_SIZE,
    parameter logic [ADDR_W-1:0] SER_BASE = DEF_SER_BASE,
    parameter int                WAIT     = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,

    output logic              bus_enable,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              sel_mem,
    output logic              sel_ser
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT);

    state_t            state, state_nx;
    logic              grant, grant_nx;       // 0 = m0, 1 = m1
    logic              last, last_nx;         // master served most recently
    logic [WAIT_W-1:0] cnt, cnt_nx;
    logic              unmapped_q, unmapped_nx;

    logic              bus_enable_nx;
    logic              bus_rw_nx;
    logic [ADDR_W-1:0] bus_addr_nx;
    logic [DATA_W-1:0] bus_wdata_nx;
    logic              sel_mem_nx;
    logic              sel_ser_nx;

    logic [DATA_W-1:0] m0_rdata_nx, m1_rdata_nx;
    logic              m0_ack_nx, m1_ack_nx;
    logic              m0_err_nx, m1_err_nx;

    logic              pick;
    logic [ADDR_W-1:0] req_addr;
    logic              dec_mem, dec_ser, dec_unmapped;

    // Lone requester wins; on contention the master that was not served last.
    assign pick     = (m0_req && m1_req) ? ~last : m1_req;
    assign req_addr = pick ? m1_addr : m0_addr;

    tenyr_addr_decode #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE),
        .SER_BASE (SER_BASE)
    ) u_decode (
        .addr     (req_addr),
        .sel_mem  (dec_mem),
        .sel_ser  (dec_ser),
        .unmapped (dec_unmapped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            unmapped_q <= 1'b0;
            bus_enable <= 1'b0;
            bus_rw     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            sel_mem    <= 1'b0;
            sel_ser    <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last       <= last_nx;
            cnt        <= cnt_nx;
            unmapped_q <= unmapped_nx;
            bus_enable <= bus_enable_nx;
            bus_rw     <= bus_rw_nx;
            bus_addr   <= bus_addr_nx;
            bus_wdata  <= bus_wdata_nx;
            sel_mem    <= sel_mem_nx;
            sel_ser    <= sel_ser_nx;
            m0_rdata   <= m0_rdata_nx;
            m1_rdata   <= m1_rdata_nx;
            m0_ack     <= m0_ack_nx;
            m1_ack     <= m1_ack_nx;
            m0_err     <= m0_err_nx;
            m1_err     <= m1_err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_nx       = last;
        cnt_nx        = cnt;
        unmapped_nx   = unmapped_q;
        bus_enable_nx = bus_enable;
        bus_rw_nx     = bus_rw;
        bus_addr_nx   = bus_addr;
        bus_wdata_nx  = bus_wdata;
        sel_mem_nx    = sel_mem;
        sel_ser_nx    = sel_ser;
        m0_rdata_nx   = m0_rdata;
        m1_rdata_nx   = m1_rdata;
        m0_ack_nx     = m0_ack;
        m1_ack_nx     = m1_ack;
        m0_err_nx     = m0_err;
        m1_err_nx     = m1_err;

        case (state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_nx      = pick;
                    bus_rw_nx     = pick ? m1_rw : m0_rw;
                    bus_addr_nx   = req_addr;
                    bus_wdata_nx  = pick ? m1_wdata : m0_wdata;
                    sel_mem_nx    = dec_mem;
                    sel_ser_nx    = dec_ser;
                    unmapped_nx   = dec_unmapped;
                    // An unmapped address still passes through ACCESS for a
                    // single cycle with the bus idle, so its ack lands one
                    // cycle after the grant like a zero-wait transfer.
                    bus_enable_nx = !dec_unmapped;
                    cnt_nx        = dec_unmapped ? '0 : WAIT_LOAD;
                    state_nx      = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (cnt == '0) begin
                    bus_enable_nx = 1'b0;
                    sel_mem_nx    = 1'b0;
                    sel_ser_nx    = 1'b0;
                    state_nx      = ST_ACK;
                    if (grant) begin
                        m1_ack_nx = 1'b1;
                        m1_err_nx = unmapped_q;
                        if (unmapped_q) begin
                            m1_rdata_nx = '0;
                        end else if (!bus_rw) begin
                            m1_rdata_nx = bus_rdata;
                        end
                    end else begin
                        m0_ack_nx = 1'b1;
                        m0_err_nx = unmapped_q;
                        if (unmapped_q) begin
                            m0_rdata_nx = '0;
                        end else if (!bus_rw) begin
                            m0_rdata_nx = bus_rdata;
                        end
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            ST_ACK: begin
                m0_ack_nx = 1'b0;
                m1_ack_nx = 1'b0;
                m0_err_nx = 1'b0;
                m1_err_nx = 1'b0;
                last_nx   = grant;
                state_nx  = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
